load_store_unit: RTL and testbench

//  Byte-addressed load/store front end for the CPU data path, directly upstream of the word-wide

---
 rtl/load_store_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Byte-addressed load/store front end for a word-wide memory that has a
//   1-cycle registered read latency. A byte/half/word request is turned into
//   one or two word beats with byte write masks; load data is aligned and
//   zero/sign-extended, and exactly one response is returned per request.
//   Build option: define LSU_MISALIGNED_EN to split accesses that cross a
//   word boundary into two beats; otherwise they are answered with an error.
module load_store_unit #(
    parameter int MEM_WIDTH_BYTES = 4,
    parameter int MEM_DEPTH       = 1024,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid_in,
    output logic                         req_ready_out,
    input  logic                         req_write_in,
    input  logic [ADDR_WIDTH-1:0]        req_addr_in,
    input  logic [1:0]                   req_size_in,
    input  logic                         req_signed_in,
    input  logic [31:0]                  req_wdata_in,
    output logic                         resp_valid_out,
    output logic [31:0]                  resp_rdata_out,
    output logic                         resp_err_out,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_write_addr_out,
    output logic                         mem_write_out,
    output logic [MEM_WIDTH_BYTES*8-1:0] mem_write_data_out,
    output logic [MEM_WIDTH_BYTES-1:0]   mem_write_mask_out,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_read_addr_out,
    output logic                         mem_read_out,
    input  logic [MEM_WIDTH_BYTES*8-1:0] mem_read_data_in,
    input  logic                         debugen_in
);
    localparam int OFF_W = $clog2(MEM_WIDTH_BYTES);
    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int MB    = MEM_WIDTH_BYTES;
    localparam int DW    = MEM_WIDTH_BYTES * 8;
    localparam int WW    = 2 * DW;
    localparam int MW    = 2 * MB;
    localparam int CW    = OFF_W + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD0  = 2'd1,
        LD1  = 2'd2,
        ST1  = 2'd3
    } state_e;

    // Byte-lane mask for an access size (low nb bits set)
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Shift a two-word window down by the byte offset and extend the low nb bytes
    function automatic logic [31:0] extract(input logic [WW-1:0]    win,
                                            input logic [OFF_W-1:0] off,
                                            input logic [1:0]       size,
                                            input logic             sgn);
        logic [WW-1:0] sh;
        logic [31:0]   v;
        sh = win >> {off, 3'b000};
        v  = sh[31:0];
        case (size)
            2'd0:    v = sgn ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
            2'd1:    v = sgn ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            default: v = v;
        endcase
        return v;
    endfunction

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [AW-1:0]     w_q, w_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              mis_q, mis_d;
    logic [DW-1:0]     hi_data_q, hi_data_d;
    logic [MB-1:0]     hi_mask_q, hi_mask_d;
    logic [DW-1:0]     beat0_q, beat0_d;

    logic [OFF_W-1:0]  req_off_s;
    logic [AW-1:0]     req_w_s;
    logic [CW-1:0]     req_end_s;
    logic              req_mis_s;
    logic              req_err_s;
    logic [WW-1:0]     st_data_s;
    logic [MW-1:0]     st_mask_s;
    logic [AW-1:0]     next_w_s;
    logic              mem_we_s, mem_re_s;
    logic [AW-1:0]     mem_waddr_s, mem_raddr_s;
    logic [DW-1:0]     mem_wdata_s;
    logic [MB-1:0]     mem_wmask_s;

    assign req_ready_out = (state_q == IDLE) && !reset;

    // Decode the incoming request: offset, word index, boundary crossing, store window
    always_comb begin
        req_off_s = req_addr_in[OFF_W-1:0];
        req_w_s   = req_addr_in[OFF_W +: AW];
        req_end_s = CW'(req_off_s) + (CW'(1) << req_size_in);
        req_mis_s = (req_end_s > CW'(MEM_WIDTH_BYTES));
`ifdef LSU_MISALIGNED_EN
        req_err_s = (req_size_in == 2'd3);
`else
        req_err_s = (req_size_in == 2'd3) || req_mis_s;
`endif
        st_data_s = WW'(req_wdata_in) << {req_off_s, 3'b000};
        st_mask_s = MW'(size_mask(req_size_in)) << req_off_s;
        next_w_s  = (w_q == AW'(MEM_DEPTH - 1)) ? {AW{1'b0}} : (w_q + AW'(1));
    end

    // Next-state, memory beat and response generation
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        w_d          = w_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
        mis_d        = mis_q;
        hi_data_d    = hi_data_q;
        hi_mask_d    = hi_mask_q;
        beat0_d      = beat0_q;
        mem_we_s     = 1'b0;
        mem_waddr_s  = w_q;
        mem_wdata_s  = {DW{1'b0}};
        mem_wmask_s  = {MB{1'b0}};
        mem_re_s     = 1'b0;
        mem_raddr_s  = w_q;
        case (state_q)
            IDLE: begin
                if (req_valid_in && req_ready_out) begin
                    w_d       = req_w_s;
                    off_d     = req_off_s;
                    size_d    = req_size_in;
                    signed_d  = req_signed_in;
                    mis_d     = req_mis_s;
                    hi_data_d = st_data_s[WW-1:DW];
                    hi_mask_d = st_mask_s[MW-1:MB];
                    if (req_err_s) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_write_in) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = req_w_s;
                        mem_wdata_s = st_data_s[DW-1:0];
                        mem_wmask_s = st_mask_s[MB-1:0];
`ifdef LSU_MISALIGNED_EN
                        if (req_mis_s) begin
                            state_d = ST1;
                        end else begin
                            resp_valid_d = 1'b1;
                        end
`else
                        resp_valid_d = 1'b1;
`endif
                    end else begin
                        mem_re_s    = 1'b1;
                        mem_raddr_s = req_w_s;
                        state_d     = LD0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LD0: begin
`ifdef LSU_MISALIGNED_EN
                if (mis_q) begin
                    beat0_d     = mem_read_data_in;
                    mem_re_s    = 1'b1;
                    mem_raddr_s = next_w_s;
                    state_d     = LD1;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract({{DW{1'b0}}, mem_read_data_in}, off_q, size_q, signed_q);
                    state_d      = IDLE;
                end
`else
                resp_valid_d = 1'b1;
                resp_rdata_d = extract({{DW{1'b0}}, mem_read_data_in}, off_q, size_q, signed_q);
                state_d      = IDLE;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            LD1: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = extract({mem_read_data_in, beat0_q}, off_q, size_q, signed_q);
                state_d      = IDLE;
            end
            ST1: begin
                mem_we_s     = 1'b1;
                mem_waddr_s  = next_w_s;
                mem_wdata_s  = hi_data_q;
                mem_wmask_s  = hi_mask_q;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, latched request fields and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            w_q          <= {AW{1'b0}};
            off_q        <= {OFF_W{1'b0}};
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            mis_q        <= 1'b0;
            hi_data_q    <= {DW{1'b0}};
            hi_mask_q    <= {MB{1'b0}};
            beat0_q      <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            w_q          <= w_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            mis_q        <= mis_d;
            hi_data_q    <= hi_data_d;
            hi_mask_q    <= hi_mask_d;
            beat0_q      <= beat0_d;
        end
    end

    assign resp_valid_out     = resp_valid_q;
    assign resp_rdata_out     = resp_rdata_q;
    assign resp_err_out       = resp_err_q;
    assign mem_write_out      = mem_we_s & ~reset;
    assign mem_read_out       = mem_re_s & ~reset;
    assign mem_write_addr_out = mem_waddr_s;
    assign mem_write_data_out = mem_wdata_s;
    assign mem_write_mask_out = mem_wmask_s;
    assign mem_read_addr_out  = mem_raddr_s;

    // Upper address bits wrap away; the trace enable only feeds simulation output
    logic unused_addr_s;
    assign unused_addr_s = ^{req_addr_in[ADDR_WIDTH-1:OFF_W+AW], debugen_in};
`ifndef LSU_MISALIGNED_EN
    // Second-beat holding registers have no reader when splitting is not built
    logic unused_split_s;
    assign unused_split_s = ^{mis_q, hi_data_q, hi_mask_q, beat0_q};
`endif

`ifndef SYNTHESIS
    // Per-cycle trace of handshake, memory strobes and response
    always_ff @(posedge clk) begin
        if (debugen_in) begin
            $write("lsu st=%0d acc=%0b we=%0b re=%0b rv=%0b err=%0b rdata=%08h\n",
                   state_q, req_valid_in && req_ready_out, mem_write_out, mem_read_out,
                   resp_valid_q, resp_err_q, resp_rdata_q);
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory,
// per-cycle compare of responses and memory strobes, directed and random requests.
module tb_load_store_unit;
    localparam int DEPTH = 1024;
    localparam int TOTAL = DEPTH * 4;
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready_out, resp_valid_out, resp_err_out;
    logic [31:0] resp_rdata_out;
    logic [9:0]  mem_write_addr_out, mem_read_addr_out;
    logic        mem_write_out, mem_read_out;
    logic [31:0] mem_write_data_out;
    logic [3:0]  mem_write_mask_out;
    logic [31:0] bmem_rd;
    logic        debugen;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid), .req_ready_out(req_ready_out),
        .req_write_in(req_write), .req_addr_in(req_addr), .req_size_in(req_size),
        .req_signed_in(req_signed), .req_wdata_in(req_wdata),
        .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out), .resp_err_out(resp_err_out),
        .mem_write_addr_out(mem_write_addr_out), .mem_write_out(mem_write_out),
        .mem_write_data_out(mem_write_data_out), .mem_write_mask_out(mem_write_mask_out),
        .mem_read_addr_out(mem_read_addr_out), .mem_read_out(mem_read_out),
        .mem_read_data_in(bmem_rd), .debugen_in(debugen)
    );

    // Word memory with registered read, as seen by the DUT
    bit [31:0] bmem [DEPTH];
    always @(posedge clk) begin
        if (mem_write_out)
            for (int b = 0; b < 4; b++)
                if (mem_write_mask_out[b]) bmem[mem_write_addr_out][8*b +: 8] <= mem_write_data_out[8*b +: 8];
        if (mem_read_out) bmem_rd <= bmem[mem_read_addr_out];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: flat byte memory plus expected-event queues
    bit [7:0] ref_mem [TOTAL];
    typedef struct { int t; logic [31:0] rdata; bit err; } resp_t;
    typedef struct { int t; int w; logic [3:0] m; logic [31:0] d; } wr_t;
    typedef struct { int t; int w; } rd_t;
    resp_t rq[$];
    wr_t   wq[$];
    rd_t   dq[$];

    int n_vec = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    int          lat, w1;
    logic [31:0] erd;
    logic [3:0]  m0, m1;
    bit          e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bytemask(input logic [3:0] m);
        logic [31:0] r;
        r = 32'd0;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
        return r;
    endfunction

    // Predict the outcome of a request accepted in cycle t
    task automatic model_accept(input int t, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                                input bit sgn, input logic [31:0] wdata,
                                output int lt, output logic [31:0] rd, output logic [3:0] k0,
                                output logic [3:0] k1, output int wn, output bit er);
        int bi, off, nb, w0;
        bit mis;
        logic [31:0] d0, d1;
        logic [63:0] v;
        resp_t r; wr_t x; rd_t y;
        bi  = int'(addr % 32'(TOTAL));
        off = bi % 4;
        nb  = 1 << size;
        w0  = bi / 4;
        wn  = (w0 + 1) % DEPTH;
        mis = (off + nb) > 4;
        er  = (size == 2'd3) || (mis && !MIS_EN);
        k0 = 4'd0; k1 = 4'd0; d0 = 32'd0; d1 = 32'd0; rd = 32'd0; lt = 1;
        if (er) begin
            lt = 1;
        end else if (wr) begin
            for (int i = 0; i < nb; i++) begin
                ref_mem[(bi + i) % TOTAL] = wdata[8*i +: 8];
                if (off + i < 4) begin k0[off+i] = 1'b1; d0[8*(off+i) +: 8] = wdata[8*i +: 8]; end
                else begin k1[off+i-4] = 1'b1; d1[8*(off+i-4) +: 8] = wdata[8*i +: 8]; end
            end
            x.t = t; x.w = w0; x.m = k0; x.d = d0; wq.push_back(x);
            if (mis) begin x.t = t + 1; x.w = wn; x.m = k1; x.d = d1; wq.push_back(x); end
            lt = mis ? 2 : 1;
        end else begin
            v = 64'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[(bi + i) % TOTAL];
            if (sgn && v[8*nb-1]) for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v[31:0];
            y.t = t; y.w = w0; dq.push_back(y);
            if (mis) begin y.t = t + 1; y.w = wn; dq.push_back(y); end
            lt = mis ? 3 : 2;
        end
        r.t = t + lt; r.rdata = rd; r.err = er; rq.push_back(r);
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] wdata);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wdata;
        n = 0;
        while (!req_ready_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_out) begin
            chk("ready_timeout", {63'd0, req_ready_out}, 64'd1);
            req_valid = 1'b0;
        end else begin
            model_accept(cyc, wr, addr, size, sgn, wdata, lat, erd, m0, m1, w1, e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom_range(0, 1)); req_addr = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_signed = 1'($urandom_range(0, 1)); req_wdata = $urandom;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        rq.delete(); wq.delete(); dq.delete();
        repeat (n) begin
            #2;
            chk("rst_mem_write", {63'd0, mem_write_out}, 64'd0);
            chk("rst_mem_read", {63'd0, mem_read_out}, 64'd0);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    // Per-cycle compare of DUT outputs against the reference model's expectations
    always begin
        bit exp_v;
        @(negedge clk);
        #2;
        if (chk_en) begin
            exp_v = (rq.size() > 0) && (rq[0].t == cyc);
            chk("resp_valid", {63'd0, resp_valid_out}, {63'd0, exp_v});
            if (exp_v) begin
                chk("resp_rdata", {32'd0, resp_rdata_out}, {32'd0, rq[0].rdata});
                chk("resp_err", {63'd0, resp_err_out}, {63'd0, rq[0].err});
                void'(rq.pop_front());
            end
            chk("rw_exclusive", {63'd0, mem_write_out & mem_read_out}, 64'd0);
            if (wq.size() > 0 && wq[0].t == cyc) begin
                chk("mem_write", {63'd0, mem_write_out}, 64'd1);
                chk("mem_waddr", {54'd0, mem_write_addr_out}, 64'(wq[0].w));
                chk("mem_wmask", {60'd0, mem_write_mask_out}, {60'd0, wq[0].m});
                chk("mem_wdata", {32'd0, mem_write_data_out & bytemask(wq[0].m)}, {32'd0, wq[0].d});
                void'(wq.pop_front());
            end else begin
                chk("mem_write_idle", {63'd0, mem_write_out}, 64'd0);
            end
            if (dq.size() > 0 && dq[0].t == cyc) begin
                chk("mem_read", {63'd0, mem_read_out}, 64'd1);
                chk("mem_raddr", {54'd0, mem_read_addr_out}, 64'(dq[0].w));
                void'(dq.pop_front());
            end else begin
                chk("mem_read_idle", {63'd0, mem_read_out}, 64'd0);
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_size = 2'd0;
        req_signed = 1'b0; req_wdata = 32'd0; debugen = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_mem_write", {63'd0, mem_write_out}, 64'd0);
        chk("rst_mem_read", {63'd0, mem_read_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_resp_valid", {63'd0, resp_valid_out}, 64'd0);
        chk("rst_resp_rdata", {32'd0, resp_rdata_out}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err_out}, 64'd0);
        chk("rst_ready", {63'd0, req_ready_out}, 64'd1);
        chk_en = 1'b1;

        // 1) reset in the middle of a load: abandoned, no response, no second beat
        do_req(1'b0, MIS_EN ? 32'h5 : 32'h4, 2'd2, 1'b0, 32'd0);
        do_reset(3);
        repeat (5) idle();
        chk("t1_ready_after_reset", {63'd0, req_ready_out}, 64'd1);

        // 2) word store then word load at 0x0
        do_req(1'b1, 32'h0, 2'd2, 1'b0, 32'h11223344);
        chk("t2_st_mask", {60'd0, m0}, 64'hF);
        chk("t2_st_lat", 64'(lat), 64'd1);
        do_req(1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        chk("t2_ld_lat", 64'(lat), 64'd2);
        chk("t2_ld_data", {32'd0, erd}, 64'h11223344);

        // 3) byte 0x80 at 0x3, signed and unsigned reload
        do_req(1'b1, 32'h3, 2'd0, 1'b0, 32'hA5A5_5A80);
        chk("t3_st_mask", {60'd0, m0}, 64'h8);
        do_req(1'b0, 32'h3, 2'd0, 1'b1, 32'h0);
        chk("t3_ld_signed", {32'd0, erd}, 64'hFFFFFF80);
        do_req(1'b0, 32'h3, 2'd0, 1'b0, 32'h0);
        chk("t3_ld_unsigned", {32'd0, erd}, 64'h00000080);

`ifdef LSU_MISALIGNED_EN
        // 4) misaligned half at 0x7
        do_req(1'b1, 32'h7, 2'd1, 1'b0, 32'h1234BEEF);
        chk("t4_st_mask0", {60'd0, m0}, 64'h8);
        chk("t4_st_mask1", {60'd0, m1}, 64'h1);
        chk("t4_st_word1", 64'(w1), 64'd2);
        chk("t4_st_lat", 64'(lat), 64'd2);
        do_req(1'b0, 32'h7, 2'd1, 1'b0, 32'h0);
        chk("t4_ld_lat", 64'(lat), 64'd3);
        chk("t4_ld_data", {32'd0, erd}, 64'h0000BEEF);

        // 5) store crossing the last word wraps to word 0
        do_req(1'b1, 32'(DEPTH * 4 - 2), 2'd2, 1'b0, 32'hCAFEF00D);
        chk("t5_wrap_word", 64'(w1), 64'd0);
        chk("t5_wrap_mask", {60'd0, m1}, 64'h3);
`endif

        // 6) errors: illegal size, and misaligned word when splitting is absent
        do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'h0);
        chk("t6_size3_err", {63'd0, e}, 64'd1);
        chk("t6_size3_lat", 64'(lat), 64'd1);
`ifndef LSU_MISALIGNED_EN
        do_req(1'b0, 32'h1, 2'd2, 1'b0, 32'h0);
        chk("t6_mis_err", {63'd0, e}, 64'd1);
        chk("t6_mis_rdata", {32'd0, erd}, 64'd0);
`endif

        // Random traffic over a small hot region, the wrap region and the full address space
        for (int k = 0; k < 400; k++) begin
            n = $urandom_range(0, 9);
            if (n < 5) a = 32'($urandom_range(0, 31));
            else if (n < 7) a = 32'(TOTAL - 16) + 32'($urandom_range(0, 15));
            else a = $urandom;
            do_req(1'($urandom_range(0, 1)), a,
                   ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), $urandom);
            n = $urandom_range(0, 3);
            if (n < 3) repeat (n) idle();
        end

        idle();
        n = 0;
        while ((rq.size() > 0 || wq.size() > 0 || dq.size() > 0) && n < 20) begin
            idle();
            n++;
        end
        if (rq.size() != 0) chk("drain_timeout", 64'(rq.size()), 64'd0);
        repeat (3) idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
